// File: rtl/garbage_scheduler_pkg.sv
// Shared definitions for the garbage scheduler.
// Contents:
//   GARBAGE_CNT_W    default width of garbage row counts
//   COMBO_BONUS_MAX  cap on the combo attack bonus
//   ATTACK_TABLE     base attack indexed by cleared lines (0-4)
//   garbage_state_t  insertion sequencer states
//   base_attack()    table lookup that returns 0 for out-of-range line counts
package garbage_scheduler_pkg;

    localparam int unsigned GARBAGE_CNT_W   = 5;
    localparam int unsigned COMBO_BONUS_MAX = 5;

    localparam logic [2:0] ATTACK_TABLE [0:4] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd4};

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        READY,
        INSERT
    } garbage_state_t;

    function automatic logic [2:0] base_attack(input logic [2:0] lines);
        logic [2:0] r_val;
        r_val = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (lines == 3'(i)) begin
                r_val = ATTACK_TABLE[i];
            end
        end
        return r_val;
    endfunction

endpackage

// File: rtl/garbage_attack_calc.sv
// Combinational attack calculator for one piece lock.
// Ports:
//   i_lock_lines   rows cleared by the lock (0-4; 5-7 treated as a non-clearing lock)
//   i_combo_count  combo count before the lock
//   i_b2b_active   back-to-back flag before the lock
//   o_attack       base + B2B bonus + combo bonus (max 10)
//   o_clearing     lock cleared at least one row
//   o_combo_next   combo count after the lock (saturates at 15)
//   o_b2b_next     back-to-back flag after the lock
module garbage_attack_calc
    import garbage_scheduler_pkg::*;
(
    input  logic [2:0] i_lock_lines,
    input  logic [3:0] i_combo_count,
    input  logic       i_b2b_active,
    output logic [3:0] o_attack,
    output logic       o_clearing,
    output logic [3:0] o_combo_next,
    output logic       o_b2b_next
);

    localparam logic [3:0] BONUS_CAP = 4'(COMBO_BONUS_MAX);

    logic       w_tetris;
    logic [3:0] w_half;
    logic [3:0] w_combo_bonus;
    logic [3:0] w_b2b_bonus;

    always_comb begin
        o_clearing    = (i_lock_lines != 3'd0) && (i_lock_lines <= 3'd4);
        w_tetris      = (i_lock_lines == 3'd4);
        w_half        = i_combo_count >> 1;
        w_combo_bonus = '0;
        if (o_clearing && i_combo_count >= 4'd2) begin
            w_combo_bonus = (w_half > BONUS_CAP) ? BONUS_CAP : w_half;
        end
        w_b2b_bonus = (w_tetris && i_b2b_active) ? 4'd1 : 4'd0;
        o_attack    = {1'b0, base_attack(i_lock_lines)} + w_b2b_bonus + w_combo_bonus;

        if (!o_clearing) begin
            o_combo_next = 4'd0;
        end else if (i_combo_count == 4'd15) begin
            o_combo_next = 4'd15;
        end else begin
            o_combo_next = i_combo_count + 4'd1;
        end

        // A 0-line lock leaves the back-to-back chain untouched.
        if (w_tetris) begin
            o_b2b_next = 1'b1;
        end else if (o_clearing) begin
            o_b2b_next = 1'b0;
        end else begin
            o_b2b_next = i_b2b_active;
        end
    end

endmodule

// File: rtl/garbage_scheduler.sv
// Garbage scheduler: turns piece locks into outgoing attacks, queues incoming garbage,
// cancels it against attacks and releases it to the playfield via insert_valid/insert_ack.
// Build option: define GARBAGE_CANCEL_EN to cancel pending garbage with outgoing attack;
// without it the full attack is always sent and pending changes only by receive/insert.
// Ports:
//   clk, rst_l       clock, synchronous active-low reset
//   game_start       synchronous clear, same effect as reset
//   lock_valid/lock_lines           piece lock pulse and rows cleared
//   recv_valid/recv_count           opponent garbage arriving
//   send_valid/send_count/send_ready  outgoing attack handshake
//   insert_valid/insert_count/insert_ack  playfield insertion handshake
//   pending_garbage  queued incoming rows
//   combo_count      consecutive clearing locks (saturating)
//   b2b_active       last clearing lock was a 4-line clear
module garbage_scheduler
    import garbage_scheduler_pkg::*;
#(
    parameter int unsigned GARBAGE_DELAY = 500_000,
    parameter int unsigned MAX_PENDING   = 20,
    parameter int unsigned MAX_INSERT    = 8,
    parameter int unsigned CNT_W         = GARBAGE_CNT_W
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             game_start,
    input  logic             lock_valid,
    input  logic [2:0]       lock_lines,
    input  logic             recv_valid,
    input  logic [CNT_W-1:0] recv_count,
    output logic             send_valid,
    output logic [CNT_W-1:0] send_count,
    input  logic             send_ready,
    output logic             insert_valid,
    output logic [CNT_W-1:0] insert_count,
    input  logic             insert_ack,
    output logic [CNT_W-1:0] pending_garbage,
    output logic [3:0]       combo_count,
    output logic             b2b_active
);

    localparam int unsigned      DLY_W    = (GARBAGE_DELAY > 1) ? $clog2(GARBAGE_DELAY) : 1;
    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(GARBAGE_DELAY - 1);
    localparam int unsigned      SUM_W    = CNT_W + 2;
    localparam logic [SUM_W-1:0] PEND_MAX = SUM_W'(MAX_PENDING);
    localparam logic [SUM_W-1:0] SEND_MAX = SUM_W'((1 << CNT_W) - 1);
    localparam logic [CNT_W-1:0] INS_MAX  = CNT_W'(MAX_INSERT);

    garbage_state_t   r_state;
    garbage_state_t   w_state_next;
    logic [DLY_W-1:0] r_delay;
    logic [CNT_W-1:0] r_pending;
    logic [CNT_W-1:0] r_send_count;
    logic [CNT_W-1:0] r_insert_count;
    logic             r_send_valid;
    logic             r_b2b;
    logic [3:0]       r_combo;

    logic [3:0]       w_calc_attack;
    logic [3:0]       w_combo_next;
    logic             w_clearing;
    logic             w_b2b_next;
    logic             w_zero_lock;
    logic             w_in_insert;
    logic [CNT_W-1:0] w_attack;
    logic [CNT_W-1:0] w_cancel;
    logic [CNT_W-1:0] w_remain;
    logic [CNT_W-1:0] w_ins_done;
    logic [CNT_W-1:0] w_recv;
    logic [CNT_W-1:0] w_pending_next;
    logic [CNT_W-1:0] w_insert_load;
    logic [SUM_W-1:0] w_pending_sum;
    logic [SUM_W-1:0] w_send_sum;
    logic             w_send_valid_next;
    logic [CNT_W-1:0] w_send_count_next;

    garbage_attack_calc u_attack_calc (
        .i_lock_lines  (lock_lines),
        .i_combo_count (r_combo),
        .i_b2b_active  (r_b2b),
        .o_attack      (w_calc_attack),
        .o_clearing    (w_clearing),
        .o_combo_next  (w_combo_next),
        .o_b2b_next    (w_b2b_next)
    );

    // Attack, cancel, pending and send-path next values.
    always_comb begin
        w_in_insert = (r_state == INSERT);
        w_attack    = lock_valid ? CNT_W'(w_calc_attack) : '0;
        w_zero_lock = lock_valid && !w_clearing;
`ifdef GARBAGE_CANCEL_EN
        // No cancel while inserting, so pending never drops below the latched insert_count.
        if (w_in_insert) begin
            w_cancel = '0;
        end else if (w_attack > r_pending) begin
            w_cancel = r_pending;
        end else begin
            w_cancel = w_attack;
        end
`else
        w_cancel = '0;
`endif
        w_remain   = w_attack - w_cancel;
        w_ins_done = (w_in_insert && insert_ack) ? r_insert_count : '0;
        w_recv     = recv_valid ? recv_count : '0;

        w_pending_sum  = SUM_W'(r_pending) + SUM_W'(w_recv) - SUM_W'(w_cancel)
                       - SUM_W'(w_ins_done);
        w_pending_next = (w_pending_sum > PEND_MAX) ? CNT_W'(MAX_PENDING)
                                                    : w_pending_sum[CNT_W-1:0];
        w_insert_load  = (w_pending_next > INS_MAX) ? INS_MAX : w_pending_next;

        w_send_sum        = SUM_W'(r_send_count) + SUM_W'(w_remain);
        w_send_valid_next = r_send_valid;
        w_send_count_next = r_send_count;
        if (w_remain != '0) begin
            w_send_valid_next = 1'b1;
            if (!r_send_valid || send_ready) begin
                w_send_count_next = w_remain;
            end else begin
                w_send_count_next = (w_send_sum > SEND_MAX) ? SEND_MAX[CNT_W-1:0]
                                                            : w_send_sum[CNT_W-1:0];
            end
        end else if (send_ready) begin
            w_send_valid_next = 1'b0;
            w_send_count_next = '0;
        end
    end

    // FSM: state register.
    always_ff @(posedge clk) begin
        if (!rst_l || game_start) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_pending_next != '0) w_state_next = ARMED;
            end
            ARMED: begin
                if (w_pending_next == '0)   w_state_next = IDLE;
                else if (r_delay == '0)     w_state_next = READY;
            end
            READY: begin
                if (w_pending_next == '0)   w_state_next = IDLE;
                else if (w_zero_lock)       w_state_next = INSERT;
            end
            INSERT: begin
                if (insert_ack) begin
                    w_state_next = (w_pending_next == '0) ? IDLE : READY;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        insert_valid    = (r_state == INSERT);
        insert_count    = insert_valid ? r_insert_count : '0;
        send_valid      = r_send_valid;
        send_count      = r_send_count;
        pending_garbage = r_pending;
        combo_count     = r_combo;
        b2b_active      = r_b2b;
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_l || game_start) begin
            r_delay        <= '0;
            r_pending      <= '0;
            r_send_valid   <= 1'b0;
            r_send_count   <= '0;
            r_insert_count <= '0;
            r_combo        <= '0;
            r_b2b          <= 1'b0;
        end else begin
            r_pending    <= w_pending_next;
            r_send_valid <= w_send_valid_next;
            r_send_count <= w_send_count_next;
            if (lock_valid) begin
                r_combo <= w_combo_next;
                r_b2b   <= w_b2b_next;
            end
            // Held loaded while idle so ARMED always starts from the full delay.
            if (r_state == IDLE) begin
                r_delay <= DLY_LOAD;
            end else if (r_state == ARMED && r_delay != '0) begin
                r_delay <= r_delay - DLY_W'(1);
            end
            if (!w_in_insert && w_state_next == INSERT) begin
                r_insert_count <= w_insert_load;
            end
        end
    end

endmodule

// File: tb/tb_garbage_scheduler.sv
module tb_garbage_scheduler;

    localparam int CNT_W = 5;
    localparam int D     = 16;
    localparam int MAXP  = 20;
    localparam int MAXI  = 8;

    logic             clk = 1'b0;
    logic             rst_l;
    logic             game_start;
    logic             lock_valid;
    logic [2:0]       lock_lines;
    logic             recv_valid;
    logic [CNT_W-1:0] recv_count;
    logic             send_valid;
    logic [CNT_W-1:0] send_count;
    logic             send_ready;
    logic             insert_valid;
    logic [CNT_W-1:0] insert_count;
    logic             insert_ack;
    logic [CNT_W-1:0] pending_garbage;
    logic [3:0]       combo_count;
    logic             b2b_active;

    always #5 clk = ~clk;

    garbage_scheduler #(
        .GARBAGE_DELAY (D),
        .MAX_PENDING   (MAXP),
        .MAX_INSERT    (MAXI),
        .CNT_W         (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_l           (rst_l),
        .game_start      (game_start),
        .lock_valid      (lock_valid),
        .lock_lines      (lock_lines),
        .recv_valid      (recv_valid),
        .recv_count      (recv_count),
        .send_valid      (send_valid),
        .send_count      (send_count),
        .send_ready      (send_ready),
        .insert_valid    (insert_valid),
        .insert_count    (insert_count),
        .insert_ack      (insert_ack),
        .pending_garbage (pending_garbage),
        .combo_count     (combo_count),
        .b2b_active      (b2b_active)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit chk;
        int pending;
        int combo;
        bit b2b;
        bit sv;
        bit iv;
    } status_t;

    status_t st_q[$];
    int      send_q[$];
    int      ins_q[$];

    // Reference model: game rules in plain arithmetic, insertion timing as an eligibility time.
    int m_pending, m_combo, m_sc, m_ins_cnt, m_elig, now;
    bit m_b2b, m_sv, m_ins, m_known;
    int atk_table[5] = '{0, 0, 1, 2, 4};

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit gs, input bit lv, input int ll,
                              input bit rv, input int rc, input bit sr, input bit ack);
        status_t s;
        int a, x, r, done, pn, combo_n;
        bit b2b_n, clearing;
        s.chk = m_known; s.pending = m_pending; s.combo = m_combo;
        s.b2b = m_b2b;   s.sv = m_sv;           s.iv = m_ins;
        st_q.push_back(s);
        if (m_known && m_sv && sr) send_q.push_back(m_sc);
        if (rst || gs) begin
            m_pending = 0; m_combo = 0; m_b2b = 0; m_sv = 0; m_sc = 0;
            m_ins = 0; m_ins_cnt = 0; m_elig = 0; m_known = 1;
            now++;
            return;
        end
        a = 0; combo_n = m_combo; b2b_n = m_b2b; clearing = lv && (ll != 0);
        if (lv) begin
            if (clearing) begin
                a = atk_table[ll];
                if (ll == 4 && m_b2b) a++;
                if (m_combo >= 2) a += imin(m_combo / 2, 5);
                b2b_n   = (ll == 4);
                combo_n = imin(m_combo + 1, 15);
            end else begin
                combo_n = 0;
            end
        end
        x = 0;
`ifdef GARBAGE_CANCEL_EN
        if (!m_ins) x = imin(a, m_pending);
`endif
        r    = a - x;
        done = (m_ins && ack) ? m_ins_cnt : 0;
        pn   = imin(m_pending - x - done + (rv ? rc : 0), MAXP);
        if (r > 0) begin
            m_sc = (m_sv && !sr) ? imin(m_sc + r, 31) : r;
            m_sv = 1;
        end else if (sr) begin
            m_sv = 0; m_sc = 0;
        end
        if (m_ins) begin
            if (ack) begin
                m_ins  = 0;
                m_elig = now + 1;
            end
        end else if (pn > 0 && m_pending == 0) begin
            m_elig = now + D + 1;
        end else if (pn > 0 && now >= m_elig && lv && !clearing) begin
            m_ins     = 1;
            m_ins_cnt = imin(pn, MAXI);
            ins_q.push_back(m_ins_cnt);
        end
        m_combo = combo_n; m_b2b = b2b_n; m_pending = pn;
        now++;
    endtask

    task automatic drive(input bit rst, input bit gs, input bit lv, input int ll,
                         input bit rv, input int rc, input bit sr, input bit ack);
        @(posedge clk);
        #1;
        rst_l      = !rst;
        game_start = gs;
        lock_valid = lv;
        lock_lines = 3'(ll);
        recv_valid = rv;
        recv_count = CNT_W'(rc);
        send_ready = sr;
        insert_ack = ack;
        model_step(rst, gs, lv, ll, rv, rc, sr, ack);
    endtask

    task automatic idle(input int n, input bit sr);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, sr, 0);
    endtask

    task automatic lock_and_see(input int ll, input int exp);
        drive(0, 0, 1, ll, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        check("tp_send_valid", send_valid, 1);
        check("tp_send_count", send_count, exp);
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard queues.
    status_t mon_s;
    bit      prev_iv = 0;
    int      cur_ins = 0;

    always @(negedge clk) begin
        if (st_q.size() > 0) begin
            mon_s = st_q.pop_front();
            if (mon_s.chk) begin
                check("pending_garbage", pending_garbage, mon_s.pending);
                check("combo_count", combo_count, mon_s.combo);
                check("b2b_active", b2b_active, int'(mon_s.b2b));
                check("send_valid", send_valid, int'(mon_s.sv));
                check("insert_valid", insert_valid, int'(mon_s.iv));
            end
        end
        if (send_valid === 1'b1 && send_ready === 1'b1) begin
            if (send_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL send_extra: got handshake count %0d, expected none", send_count);
            end else begin
                check("send_count", send_count, send_q.pop_front());
            end
        end
        if (insert_valid === 1'b1 && !prev_iv) begin
            if (ins_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL insert_extra: got request count %0d, expected none", insert_count);
            end else begin
                cur_ins = ins_q.pop_front();
                check("insert_count", insert_count, cur_ins);
            end
        end else if (insert_valid === 1'b1) begin
            check("insert_count_stable", insert_count, cur_ins);
        end
        prev_iv = (insert_valid === 1'b1);
    end

    initial begin
        m_known = 0; now = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("reset_pending", pending_garbage, 0);
        check("reset_send_valid", send_valid, 0);
        check("reset_insert_valid", insert_valid, 0);
        check("reset_combo", combo_count, 0);

        // Four 2-line locks: combo bonus kicks in from combo 2.
        lock_and_see(2, 1);
        lock_and_see(2, 1);
        lock_and_see(2, 2);
        lock_and_see(2, 2);
        check("tp1_combo", combo_count, 4);
        check("tp1_b2b", b2b_active, 0);

        // Tetris, 0-line, tetris: second tetris gets the B2B bonus.
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        lock_and_see(4, 4);
        drive(0, 0, 1, 0, 0, 0, 1, 0);
        lock_and_see(4, 5);
        check("tp2_b2b", b2b_active, 1);
        check("tp2_combo", combo_count, 1);

        // Receive 6 then a tetris: cancelled or sent depending on build.
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 6, 1, 0);
        drive(0, 0, 1, 4, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
`ifdef GARBAGE_CANCEL_EN
        check("tp3_pending", pending_garbage, 2);
        check("tp3_send_valid", send_valid, 0);
`else
        check("tp3_pending", pending_garbage, 6);
        check("tp3_send_count", send_count, 4);
`endif
        idle(1, 1);

        // Receive 10, wait out the delay, insert 8 then the remaining 2.
        drive(0, 1, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 10, 1, 0);
        idle(D + 2, 1);
        drive(0, 0, 1, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        check("tp4_insert_valid", insert_valid, 1);
        check("tp4_insert_count", insert_count, 8);
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        check("tp4_pending_after_ack", pending_garbage, 2);
        check("tp4_insert_dropped", insert_valid, 0);
        drive(0, 0, 1, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        check("tp4_insert_count2", insert_count, 2);
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        check("tp4_pending_empty", pending_garbage, 0);

        // Link stalled: attacks 4 and 2 accumulate; receive saturates at MAX_PENDING.
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 4, 0, 0, 0, 0);
        drive(0, 0, 1, 3, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 15, 0, 0);
        drive(0, 0, 0, 0, 1, 15, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("tp5_send_count", send_count, 6);
        check("tp5_pending_sat", pending_garbage, 20);
        idle(2, 1);

        // game_start during an insertion clears everything.
        drive(0, 1, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 9, 1, 0);
        idle(D + 2, 1);
        drive(0, 0, 1, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        check("tp6_insert_valid", insert_valid, 1);
        check("tp6_pending", pending_garbage, 9);
        drive(0, 1, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        check("tp6_insert_cleared", insert_valid, 0);
        check("tp6_insert_count", insert_count, 0);
        check("tp6_pending_cleared", pending_garbage, 0);
        check("tp6_send_cleared", send_valid, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit gs, lv, rv, sr, ack;
            int ll, rc;
            gs  = ($urandom_range(0, 599) == 0);
            lv  = ($urandom_range(0, 3) == 0);
            ll  = $urandom_range(0, 4);
            rv  = ($urandom_range(0, 15) == 0);
            rc  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(1, 6);
            sr  = ($urandom_range(0, 2) != 0);
            ack = m_ins ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            drive(0, gs, lv, ll, rv, rc, sr, ack);
        end
        idle(4, 1);
        @(negedge clk);
        check("send_queue_drained", send_q.size(), 0);
        check("insert_queue_drained", ins_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
